// File: rtl/stopwatch_pkg.sv
// Shared encodings and sizing helpers for the stopwatch control slice.
package stopwatch_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRun     = 3'd1;
    localparam logic [2:0] StPause   = 3'd2;
    localparam logic [2:0] StLap     = 3'd3;
    localparam logic [2:0] StLapStop = 3'd4;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned calc_presc_w(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_press;
    logic [CntW-1:0] r_cnt;

    // Level flips on the DEB_CYCLES-th consecutive differing sample; press marks 0->1 only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntW'(DEB_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button events, run/pause/lap FSM, and 100 Hz count-enable prescaler.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_sel,
    output logic       running,
    output logic [2:0] state
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PW  = calc_presc_w(DIV);

    logic          w_ev_ss;
    logic          w_ev_lr;
    logic [2:0]    w_state_d;
    logic          w_lap_load_d;
    logic          w_cnt_clr_d;
    logic          w_run_d;
    logic          w_disp_d;
    logic          w_advance;
    logic          w_wrap;
    logic [2:0]    r_state;
    logic          r_running;
    logic          r_disp_sel;
    logic          r_lap_load;
    logic          r_cnt_clr;
    logic          r_cnt_en;
    logic [PW-1:0] r_presc;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_ss),
        .o_press (w_ev_ss)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_lr),
        .o_press (w_ev_lr)
    );

    // Start/stop wins when both events land together.
    always_comb begin
        w_state_d    = r_state;
        w_lap_load_d = 1'b0;
        w_cnt_clr_d  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_ev_ss) w_state_d = StRun;
            end
            StRun: begin
                if (w_ev_ss) begin
                    w_state_d = StPause;
                end else if (w_ev_lr) begin
                    w_state_d    = StLap;
                    w_lap_load_d = 1'b1;
                end
            end
            StLap: begin
                if (w_ev_ss)      w_state_d = StLapStop;
                else if (w_ev_lr) w_state_d = StRun;
            end
            StLapStop: begin
                if (w_ev_ss)      w_state_d = StLap;
                else if (w_ev_lr) w_state_d = StPause;
            end
            StPause: begin
                if (w_ev_ss) begin
                    w_state_d = StRun;
                end else if (w_ev_lr) begin
                    w_state_d   = StIdle;
                    w_cnt_clr_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_run_d  = (w_state_d == StRun) || (w_state_d == StLap);
    assign w_disp_d = (w_state_d == StLap) || (w_state_d == StLapStop);
    // Advancing only when running on both sides of the edge keeps a stop-on-wrap from losing the tick.
    assign w_advance = r_running && w_run_d;
    assign w_wrap    = (r_presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_running  <= 1'b0;
            r_disp_sel <= 1'b0;
            r_lap_load <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_cnt_en   <= 1'b0;
            r_presc    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_running  <= w_run_d;
            r_disp_sel <= w_disp_d;
            r_lap_load <= w_lap_load_d;
            r_cnt_clr  <= w_cnt_clr_d;
            r_cnt_en   <= w_advance && w_wrap;
            if (w_cnt_clr_d) begin
                r_presc <= '0;
            end else if (w_advance) begin
                r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            end
        end
    end

    assign state    = r_state;
    assign running  = r_running;
    assign disp_sel = r_disp_sel;
    assign lap_load = r_lap_load;
    assign cnt_clr  = r_cnt_clr;
    assign cnt_en   = r_cnt_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-cycle debounce window.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lr;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_load;
    logic       disp_sel;
    logic       running;
    logic [2:0] state;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pulse = 0;
    int base;

    stopwatch_ctrl #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .DEB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .lap_load (lap_load),
        .disp_sel (disp_sel),
        .running  (running),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cnt_en === 1'b1) n_pulse <= n_pulse + 1;

    initial begin
        #100000;
        $error("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input string tag, input int max);
        int k = 0;
        do begin
            tick(1);
            k++;
        end while (cnt_en !== 1'b1 && k < max);
        chk(tag, {7'd0, cnt_en}, 8'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, {5'd0, state}, 8'd0);
        chk({tag, "_running"}, {7'd0, running}, 8'd0);
        chk({tag, "_cnt_en"}, {7'd0, cnt_en}, 8'd0);
        chk({tag, "_cnt_clr"}, {7'd0, cnt_clr}, 8'd0);
        chk({tag, "_lap_load"}, {7'd0, lap_load}, 8'd0);
        chk({tag, "_disp_sel"}, {7'd0, disp_sel}, 8'd0);
    endtask

    initial begin
        rst    = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        tick(2);
        chk_all_zero("reset");
        rst = 1'b1;
        tick(2);

        // Bounce shorter than the debounce window must not register.
        base = n_pulse;
        for (int i = 0; i < 12; i++) begin
            btn_ss = ((i >> 1) & 1) == 0;
            tick(1);
        end
        btn_ss = 1'b0;
        tick(12);
        chk("bounce_state", {5'd0, state}, 8'd0);
        chk("bounce_pulses", 8'(n_pulse - base), 8'd0);

        // Clean press: event after 6 edges, RUN after 7, first tick 10 later.
        btn_ss = 1'b1;
        tick(6);
        chk("start_pre_state", {5'd0, state}, 8'd0);
        tick(1);
        chk("start_state", {5'd0, state}, 8'd1);
        chk("start_running", {7'd0, running}, 8'd1);
        tick(9);
        chk("first_en_early", {7'd0, cnt_en}, 8'd0);
        tick(1);
        chk("first_en", {7'd0, cnt_en}, 8'd1);
        tick(3);
        btn_ss = 1'b0;
        base = n_pulse;
        tick(50);
        chk("five_pulses", 8'(n_pulse - base), 8'd5);

        // Press on a tick cycle so the stop event lands with prescaler=6.
        wait_en("pause_align", 12);
        btn_ss = 1'b1;
        tick(7);
        chk("pause_state", {5'd0, state}, 8'd2);
        chk("pause_running", {7'd0, running}, 8'd0);
        tick(1);
        btn_ss = 1'b0;
        base = n_pulse;
        tick(30);
        chk("pause_no_pulse", 8'(n_pulse - base), 8'd0);

        btn_ss = 1'b1;
        tick(7);
        chk("resume_state", {5'd0, state}, 8'd1);
        tick(3);
        chk("resume_en_early", {7'd0, cnt_en}, 8'd0);
        tick(1);
        chk("resume_en", {7'd0, cnt_en}, 8'd1);
        btn_ss = 1'b0;

        wait_en("lap_align", 12);
        btn_lr = 1'b1;
        tick(7);
        chk("lap_state", {5'd0, state}, 8'd3);
        chk("lap_load_hi", {7'd0, lap_load}, 8'd1);
        chk("lap_disp", {7'd0, disp_sel}, 8'd1);
        chk("lap_running", {7'd0, running}, 8'd1);
        tick(1);
        chk("lap_load_lo", {7'd0, lap_load}, 8'd0);
        btn_lr = 1'b0;
        tick(2);
        chk("lap_en_continues", {7'd0, cnt_en}, 8'd1);

        btn_ss = 1'b1;
        tick(7);
        chk("lapstop_state", {5'd0, state}, 8'd4);
        chk("lapstop_running", {7'd0, running}, 8'd0);
        chk("lapstop_disp", {7'd0, disp_sel}, 8'd1);
        tick(1);
        btn_ss = 1'b0;
        base = n_pulse;
        tick(20);
        chk("lapstop_no_pulse", 8'(n_pulse - base), 8'd0);

        btn_lr = 1'b1;
        tick(7);
        chk("lapstop_pause_state", {5'd0, state}, 8'd2);
        chk("lapstop_pause_disp", {7'd0, disp_sel}, 8'd0);
        tick(1);
        btn_lr = 1'b0;
        tick(8);

        btn_lr = 1'b1;
        tick(7);
        chk("clear_state", {5'd0, state}, 8'd0);
        chk("clear_hi", {7'd0, cnt_clr}, 8'd1);
        tick(1);
        chk("clear_lo", {7'd0, cnt_clr}, 8'd0);
        btn_lr = 1'b0;
        tick(8);

        // Both buttons together: start wins, no clear, prescaler restarts from 0.
        btn_ss = 1'b1;
        btn_lr = 1'b1;
        tick(7);
        chk("both_state", {5'd0, state}, 8'd1);
        chk("both_lap_load", {7'd0, lap_load}, 8'd0);
        chk("both_clr", {7'd0, cnt_clr}, 8'd0);
        tick(1);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        tick(8);
        chk("cleared_en_early", {7'd0, cnt_en}, 8'd0);
        tick(1);
        chk("cleared_en", {7'd0, cnt_en}, 8'd1);

        btn_lr = 1'b1;
        tick(7);
        chk("rst_lap_state", {5'd0, state}, 8'd3);
        tick(1);
        btn_lr = 1'b0;
        tick(1);
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        base = n_pulse;
        tick(20);
        chk("post_rst_state", {5'd0, state}, 8'd0);
        chk("post_rst_pulses", 8'(n_pulse - base), 8'd0);

        btn_ss = 1'b1;
        tick(7);
        chk("post_rst_start", {5'd0, state}, 8'd1);
        btn_ss = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch counter chain (centiseconds 0–99 feeding the seconds/minutes counters). It debounces the two user buttons (start/stop, lap/reset), runs the run/pause/lap/clear sequence, and divides the system clock into a 100 Hz count-enable pulse. Downstream counters are clocked by the system clk with cnt_en as a synchronous enable; no gated clocks exist anywhere in the chain. It also drives lap-register capture and display selection.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
TICK_HZ, 100, count-enable rate in Hz; DIV = CLK_HZ/TICK_HZ, and DIV must be ≥ 2.
DEB_CYCLES, 500_000, consecutive stable synchronized cycles required to accept a button level change.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, asynchronous, active-low.
btn_ss  in  1  raw start/stop button, asynchronous, active-high.
btn_lr  in  1  raw lap/reset button, asynchronous, active-high.
cnt_en  out  1  one-cycle count-enable pulse at TICK_HZ while counting.
cnt_clr  out  1  one-cycle synchronous clear to the counter chain.
lap_load  out  1  one-cycle pulse; the datapath copies the live count into the lap register.
disp_sel  out  1  display source: 0 = live count, 1 = lap register.
running  out  1  high while the counter advances.
state  out  3  current FSM state, for debug and LEDs.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, prescaler=0, debounce state cleared. All outputs are 0.
- Button path:
  - Each button passes through a 2-flop synchronizer, then the debouncer.
  - The debounced level changes only after the synchronized input has held the new value for DEB_CYCLES consecutive cycles.
  - A press event (ev_ss or ev_lr) is a one-cycle pulse on the debounced 0->1 edge. Release produces no event.
  - Latency from a clean raw edge to the event is 2 + DEB_CYCLES cycles, ±1.
- Simultaneous ev_ss and ev_lr in the same cycle: ev_ss is acted on and ev_lr is dropped.
- State transitions (state registers on the edge where the event is high):
  - IDLE: ev_ss -> RUN. ev_lr is ignored.
  - RUN: ev_ss -> PAUSE. ev_lr -> LAP, and lap_load=1 for that one cycle.
  - LAP (counting, display frozen): ev_lr -> RUN. ev_ss -> LAP_STOP.
  - LAP_STOP (stopped, display frozen): ev_ss -> LAP. ev_lr -> PAUSE.
  - PAUSE: ev_ss -> RUN. ev_lr -> IDLE, and cnt_clr=1 for that one cycle.
- Outputs are registered from state and are valid the cycle after the transition:
  - running=1 in RUN and LAP.
  - disp_sel=1 in LAP and LAP_STOP.
  - lap_load and cnt_clr are registered one-cycle pulses, asserted in the cycle after the triggering event.
- Prescaler:
  - Counts 0..DIV-1 only while running=1. When it wraps DIV-1 -> 0, cnt_en=1 for exactly one cycle.
  - Holds its value while stopped, so a paused fraction is preserved.
  - Reset to 0 together with cnt_clr.
  - The first cnt_en after IDLE->RUN comes DIV cycles after running rises.
- No cnt_en is asserted in the cycle running falls. A stop event on the same edge as the wrap suppresses that pulse.
- Reset mid-operation returns to IDLE at once. Counter-chain clearing on reset is the datapath's own rst; cnt_clr is not asserted.

Decomposition:
- stopwatch_pkg holds:
  - state encodings: IDLE=0, RUN=1, PAUSE=2, LAP=3, LAP_STOP=4;
  - the function that computes DIV;
  - prescaler width = clog2(DIV).
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse) is instantiated twice, with parameter DEB_CYCLES.

Test Plan (CLK_HZ=1000, TICK_HZ=100 so DIV=10; DEB_CYCLES=4):
- Reset, then btn_ss held 1 for 20 cycles -> state=RUN about 7 cycles after the press. cnt_en pulses every 10 cycles, the first 10 cycles after running rises, 5 pulses in 50 cycles.
- Bounce: btn_ss toggles every 2 cycles for 12 cycles, then settles to 0 -> no event; state stays IDLE and cnt_en stays 0.
- RUN, then ev_ss at prescaler=6, 30 idle cycles, then ev_ss -> no cnt_en while in PAUSE. The first pulse after resuming comes 3 or 4 cycles later, confirming the prescaler was held.
- RUN -> ev_lr -> lap_load one cycle and disp_sel=1, cnt_en continues. Then ev_ss -> LAP_STOP, cnt_en stops. Then ev_lr -> PAUSE with disp_sel=0.
- PAUSE -> ev_lr -> cnt_clr one cycle, state=IDLE, prescaler=0. Both buttons pressed on the same cycle from IDLE -> RUN, with no clear.
- rst pulsed low in LAP mid-prescale -> all outputs 0 immediately and state=IDLE. After release, no event occurs until a new debounced press.
